// File: rtl/i2c_slave.sv
// I2C target with an 8-bit register-pointer protocol. SCL/SDA are oversampled on clk.
// SDA is only ever pulled low; SCL is never driven.
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iic_scl_i,
  input  logic       iic_sda_i,
  output logic       iic_sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       iic_busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_DEV_ACK,
    ST_REGADDR,
    ST_REG_ACK,
    ST_WDATA,
    ST_W_ACK,
    ST_RDATA,
    ST_R_ACK,
    ST_IGNORE
  } state_t;

  state_t      state_r;
  logic [1:0]  scl_sync_r;
  logic [1:0]  sda_sync_r;
  logic        scl_d_r;
  logic        sda_d_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        rd_load_r;

  logic        scl_s;
  logic        sda_s;
  logic        scl_rise_s;
  logic        scl_fall_s;
  logic        sda_rise_s;
  logic        sda_fall_s;
  logic        start_s;
  logic        stop_s;
  logic [7:0]  rx_byte_s;

  // Pin synchronisers plus one delay stage for edge detection (idle bus reads high)
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], iic_scl_i};
      sda_sync_r <= {sda_sync_r[0], iic_sda_i};
      scl_d_r    <= scl_sync_r[1];
      sda_d_r    <= sda_sync_r[1];
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  assign sda_rise_s = sda_s & ~sda_d_r;
  assign sda_fall_s = ~sda_s & sda_d_r;
  // SDA edges only count as bus conditions while SCL has been stable high
  assign start_s    = sda_fall_s & scl_s & scl_d_r;
  assign stop_s     = sda_rise_s & scl_s & scl_d_r;
  assign rx_byte_s  = {shift_r[6:0], sda_s};

  // Protocol FSM with registered bus and register-file outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      rd_load_r  <= 1'b0;
      iic_sda_oe <= 1'b0;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      iic_busy   <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (start_s) begin
        state_r    <= ST_DEVADDR;
        bit_cnt_r  <= 4'd0;
        rd_load_r  <= 1'b0;
        iic_sda_oe <= 1'b0;
        iic_busy   <= 1'b0;
      end else if (stop_s) begin
        state_r    <= ST_IDLE;
        bit_cnt_r  <= 4'd0;
        rd_load_r  <= 1'b0;
        iic_sda_oe <= 1'b0;
        iic_busy   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            iic_sda_oe <= 1'b0;
          end
          ST_DEVADDR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              bit_cnt_r <= 4'd0;
              if (shift_r[7:1] == DEV_ADDR) begin
                state_r    <= ST_DEV_ACK;
                iic_sda_oe <= 1'b1;
                iic_busy   <= 1'b1;
              end else begin
                state_r    <= ST_IGNORE;
                iic_sda_oe <= 1'b0;
              end
            end
          end
          ST_DEV_ACK: begin
            // shift_r[0] still holds the R/W bit of the address byte
            if (scl_fall_s) begin
              bit_cnt_r  <= 4'd0;
              iic_sda_oe <= 1'b0;
              if (shift_r[0]) begin
                state_r   <= ST_RDATA;
                reg_rd    <= 1'b1;
                rd_load_r <= 1'b1;
              end else begin
                state_r <= ST_REGADDR;
              end
            end
          end
          ST_REGADDR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                reg_addr <= rx_byte_s;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              state_r    <= ST_REG_ACK;
              iic_sda_oe <= 1'b1;
            end
          end
          ST_REG_ACK: begin
            if (scl_fall_s) begin
              state_r    <= ST_WDATA;
              bit_cnt_r  <= 4'd0;
              iic_sda_oe <= 1'b0;
            end
          end
          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                reg_wdata <= rx_byte_s;
                reg_wr    <= 1'b1;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              state_r    <= ST_W_ACK;
              iic_sda_oe <= 1'b1;
            end
          end
          ST_W_ACK: begin
            if (scl_fall_s) begin
              state_r    <= ST_WDATA;
              bit_cnt_r  <= 4'd0;
              iic_sda_oe <= 1'b0;
              reg_addr   <= reg_addr + 8'd1;
            end
          end
          ST_RDATA: begin
            // bit_cnt_r counts bits already placed on SDA
            if (rd_load_r) begin
              shift_r    <= reg_rdata;
              iic_sda_oe <= ~reg_rdata[7];
              rd_load_r  <= 1'b0;
              bit_cnt_r  <= 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                state_r    <= ST_R_ACK;
                bit_cnt_r  <= 4'd0;
                iic_sda_oe <= 1'b0;
              end else begin
                shift_r    <= {shift_r[6:0], 1'b0};
                iic_sda_oe <= ~shift_r[6];
                bit_cnt_r  <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_R_ACK: begin
            // bit_cnt_r = 1 records that the master acknowledged this byte
            if (scl_rise_s) begin
              if (!sda_s) begin
                reg_addr  <= reg_addr + 8'd1;
                bit_cnt_r <= 4'd1;
              end else begin
                state_r <= ST_IGNORE;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
              state_r   <= ST_RDATA;
              bit_cnt_r <= 4'd0;
              reg_rd    <= 1'b1;
              rd_load_r <= 1'b1;
            end
          end
          ST_IGNORE: begin
            iic_sda_oe <= 1'b0;
          end
          default: begin
            state_r    <= ST_IDLE;
            iic_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, table of write transactions, read and corner sequences.
// Register-file strobes are collected into queues and compared against expectations.
module tb_i2c_slave;

  localparam int Q = 5;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_line;
  logic       iic_sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       iic_busy;

  int checks;
  int errors;
  logic oe_seen;

  logic [15:0] exp_wr[$];
  logic [15:0] obs_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  obs_rd[$];

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[5];

  assign sda_line  = m_sda & ~iic_sda_oe;
  assign reg_rdata = reg_addr ^ 8'hB6;

  i2c_slave #(.DEV_ADDR(7'h50)) dut (
    .clk        (clk),
    .rst        (rst),
    .iic_scl_i  (m_scl),
    .iic_sda_i  (sda_line),
    .iic_sda_oe (iic_sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .iic_busy   (iic_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) obs_wr.push_back({reg_addr, reg_wdata});
    if (reg_rd) obs_rd.push_back(reg_addr);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    return a ^ 8'hB6;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) begin
      @(negedge clk);
      if (iic_sda_oe) oe_seen = 1'b1;
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic bit_v;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(bit_v);
    acked = ~bit_v;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
  endtask

  task automatic check_sb();
    logic [15:0] e16;
    logic [15:0] o16;
    logic [7:0]  e8;
    logic [7:0]  o8;
    while (exp_wr.size() > 0 || obs_wr.size() > 0) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        o16 = obs_wr.pop_front();
        $display("FAIL reg_wr_unexpected: got addr_data %h expected none", o16);
      end else if (obs_wr.size() == 0) begin
        errors++;
        e16 = exp_wr.pop_front();
        $display("FAIL reg_wr_missing: got none expected addr_data %h", e16);
      end else begin
        e16 = exp_wr.pop_front();
        o16 = obs_wr.pop_front();
        if (o16 !== e16) begin
          errors++;
          $display("FAIL reg_wr: got addr_data %h expected %h", o16, e16);
        end
      end
    end
    while (exp_rd.size() > 0 || obs_rd.size() > 0) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        o8 = obs_rd.pop_front();
        $display("FAIL reg_rd_unexpected: got addr %h expected none", o8);
      end else if (obs_rd.size() == 0) begin
        errors++;
        e8 = exp_rd.pop_front();
        $display("FAIL reg_rd_missing: got none expected addr %h", e8);
      end else begin
        e8 = exp_rd.pop_front();
        o8 = obs_rd.pop_front();
        if (o8 !== e8) begin
          errors++;
          $display("FAIL reg_rd: got addr %h expected %h", o8, e8);
        end
      end
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rbyte;
    logic [7:0] exp_ptr;

    vecs[0] = '{8'hA0, 8'h10, 8'h5A, 8'h3C, 1'b1};
    vecs[1] = '{8'hA2, 8'h33, 8'h44, 8'h55, 1'b0};
    vecs[2] = '{8'hA0, 8'hFF, 8'h11, 8'h22, 1'b1};
    vecs[3] = '{8'h00, 8'h12, 8'h34, 8'h56, 1'b0};
    vecs[4] = '{8'hA0, 8'h80, 8'hC3, 8'h01, 1'b1};

    checks  = 0;
    errors  = 0;
    oe_seen = 1'b0;
    exp_ptr = 8'h00;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    rst     = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {iic_sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, iic_busy}, 32'h0);
    wait_q();

    // Table of write transactions
    for (int v = 0; v < 5; v++) begin
      oe_seen = 1'b0;
      i2c_start();
      send_byte(vecs[v].addr_byte, ack);
      check("dev_ack", ack, vecs[v].exp_ack);
      check("busy_after_addr", iic_busy, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        exp_wr.push_back({vecs[v].ptr, vecs[v].d0});
        exp_wr.push_back({vecs[v].ptr + 8'd1, vecs[v].d1});
        exp_ptr = vecs[v].ptr + 8'd2;
      end
      send_byte(vecs[v].ptr, ack);
      check("ptr_ack", ack, vecs[v].exp_ack);
      send_byte(vecs[v].d0, ack);
      check("d0_ack", ack, vecs[v].exp_ack);
      send_byte(vecs[v].d1, ack);
      check("d1_ack", ack, vecs[v].exp_ack);
      i2c_stop();
      check("busy_after_stop", iic_busy, 1'b0);
      check("sda_released", iic_sda_oe, 1'b0);
      check("reg_addr_after", reg_addr, exp_ptr);
      if (!vecs[v].exp_ack) check("sda_never_low", oe_seen, 1'b0);
      check_sb();
    end

    // Combined write-pointer then repeated-START read
    i2c_start();
    send_byte(8'hA0, ack);
    check("rd_dev_w_ack", ack, 1'b1);
    send_byte(8'h20, ack);
    check("rd_ptr_ack", ack, 1'b1);
    i2c_start();
    send_byte(8'hA1, ack);
    check("rd_dev_r_ack", ack, 1'b1);
    exp_rd.push_back(8'h20);
    exp_rd.push_back(8'h21);
    recv_byte(rbyte);
    check("rd_byte0", rbyte, rd_model(8'h20));
    write_bit(1'b0);
    recv_byte(rbyte);
    check("rd_byte1", rbyte, rd_model(8'h21));
    write_bit(1'b1);
    check("busy_after_nack", iic_busy, 1'b1);
    i2c_stop();
    check("rd_busy_after_stop", iic_busy, 1'b0);
    check("rd_reg_addr", reg_addr, 8'h21);
    check_sb();

    // Synchronous reset at bit 4 of a data byte
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    check("rst_ptr_ack", ack, 1'b1);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    check("busy_before_rst", iic_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_sda_oe", iic_sda_oe, 1'b0);
    check("rst_busy", iic_busy, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    rst = 1'b0;
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
    oe_seen = 1'b0;
    read_bit(ack);
    check("rst_no_ack", ack, 1'b1);
    i2c_stop();
    check("rst_sda_never_low", oe_seen, 1'b0);
    check_sb();
    i2c_start();
    send_byte(8'hA0, ack);
    check("post_rst_dev_ack", ack, 1'b1);
    send_byte(8'h40, ack);
    exp_wr.push_back({8'h40, 8'h77});
    send_byte(8'h77, ack);
    check("post_rst_data_ack", ack, 1'b1);
    i2c_stop();
    check("post_rst_reg_addr", reg_addr, 8'h41);
    check_sb();

    // STOP in the middle of a data byte
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h50, ack);
    check("stop_mid_ptr_ack", ack, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_stop();
    check("stop_mid_busy", iic_busy, 1'b0);
    check("stop_mid_sda", iic_sda_oe, 1'b0);
    check("stop_mid_reg_addr", reg_addr, 8'h50);
    check_sb();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
